// File: rtl/pipe_pkg.sv
// ============================================================================
// Module     : pipe_pkg
// Description: Shared constants for the elastic pipeline stage.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;

    localparam int c_CTRL_W_DEFAULT = 4;

    localparam int c_DEPTH_MIN = 1;
    localparam int c_DEPTH_MAX = 4;

    function automatic bit depth_legal(input int depth);
        return (depth >= c_DEPTH_MIN) && (depth <= c_DEPTH_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
// ============================================================================
// Module     : pipe_sat_cnt
// Description: 32-bit saturating event counter with enable and sync clear.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_sat_cnt (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// Module     : pipe_stage_elastic
// Description: Elastic pipeline stage register with DEPTH-entry skid buffer,
//              flush and optional perf counters (macro PIPE_STAGE_PERF_EN).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2,
    parameter int CTRL_W = c_CTRL_W_DEFAULT,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [CTRL_W-1:0]        ctrl_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    output logic [CTRL_W-1:0]        ctrl_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              bubble_cnt_o
);

    localparam int c_DW    = NUM_CH * DATA_W;
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    generate
        if (!depth_legal(DEPTH) || (NUM_CH < 1)) begin : g_param_check
            $error("pipe_stage_elastic: DEPTH or NUM_CH out of range");
        end
    endgenerate

    logic [CTRL_W-1:0]  ctrl_q [DEPTH];
    logic [c_DW-1:0]    data_q [DEPTH];
    logic [ADDR_W-1:0]  addr_q [DEPTH];

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;

    logic w_push;
    logic w_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // ready depends only on the occupancy register, never on stall_i
    assign ready_o = (count_q < c_FULL);
    assign valid_o = (count_q != '0);
    assign w_push  = valid_i & ready_o;
    assign w_pop   = valid_o & ~stall_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (w_push && !flush_i) begin
                ctrl_q[wr_ptr_q] <= ctrl_i;
                data_q[wr_ptr_q] <= data_i;
                addr_q[wr_ptr_q] <= rd_addr_i;
            end
        end
    end

    // a bubble must never carry write enables downstream
    assign ctrl_o    = valid_o ? ctrl_q[rd_ptr_q] : '0;
    assign data_o    = data_q[rd_ptr_q];
    assign rd_addr_o = addr_q[rd_ptr_q];

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .en_i  (valid_o & stall_i),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_cnt u_bubble_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .en_i  (~valid_o & ~stall_i),
        .cnt_o (bubble_cnt_o)
    );
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

`default_nettype wire
